// File: rtl/data_memory_sized.sv
// data_memory_sized
// Byte-addressed, little-endian data memory for the MIPS MEM stage.
// Supports byte/halfword/word loads (sign or zero extended) and stores,
// behind a valid/ready request with a configurable wait latency and a
// single-cycle response pulse. Misaligned and out-of-range accesses are
// reported as flags, leave memory untouched and return zero.
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous, active-high
//   req_valid     request present
//   req_ready     request can be accepted (IDLE only)
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   address       byte address
//   write_data    store data, low bytes used according to size
//   resp_valid    one-cycle response pulse
//   read_data     extended load result (0 for stores and faults)
//   misaligned    alignment / illegal-size fault, valid with resp_valid
//   out_of_range  range fault, valid with resp_valid
module data_memory_sized #(
  parameter int unsigned DEPTH_BYTES  = 1024,
  parameter int unsigned LATENCY      = 1,
  parameter bit          INIT_PATTERN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Power-up image of the byte array; reset never touches it.
  function automatic logic [DEPTH_BYTES*8-1:0] init_image();
    logic [DEPTH_BYTES*8-1:0] img;
    img = '0;
    for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
      img[i*8 +: 8] = INIT_PATTERN ? 8'(i) : 8'h00;
    end
    return img;
  endfunction

  logic [DEPTH_BYTES*8-1:0] mem = init_image();

  state_t        state, state_next;
  logic [CW-1:0] cnt;

  logic          lat_write;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;

  logic          access;
  logic [3:0]    byte_en;
  logic [32:0]   last_addr;
  logic          mis_c;
  logic          oor_c;
  logic          fault;
  logic [AW-1:0] idx [4];
  logic [7:0]    rbyte [4];
  logic [31:0]   load_val;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign access     = (state == WAIT) && (cnt == '0);

  always_comb begin
    byte_en   = 4'b1111;
    last_addr = '0;
    mis_c     = 1'b0;
    oor_c     = 1'b0;
    fault     = 1'b0;
    load_val  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx[k]   = '0;
      rbyte[k] = '0;
    end

    case (lat_size)
      2'b00:   byte_en = 4'b0001;
      2'b01:   byte_en = 4'b0011;
      default: byte_en = 4'b1111;
    endcase

    case (lat_size)
      2'b01:   mis_c = lat_addr[0];
      2'b10:   mis_c = (lat_addr[1:0] != 2'b00);
      2'b11:   mis_c = 1'b1;
      default: mis_c = 1'b0;
    endcase

    // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap back into range.
    case (lat_size)
      2'b00:   last_addr = {1'b0, lat_addr};
      2'b01:   last_addr = {1'b0, lat_addr} + 33'd1;
      default: last_addr = {1'b0, lat_addr} + 33'd3;
    endcase
    oor_c = (last_addr >= 33'(DEPTH_BYTES));
    fault = mis_c | oor_c;

    // Index arithmetic wraps in AW bits; only used when the access is in range.
    for (int unsigned k = 0; k < 4; k++) begin
      idx[k]   = lat_addr[AW-1:0] + AW'(k);
      rbyte[k] = mem[{idx[k], 3'b000} +: 8];
    end

    if (!lat_write && !fault) begin
      case (lat_size)
        2'b00:   load_val = lat_unsigned ? {24'h0, rbyte[0]}
                                         : {{24{rbyte[0][7]}}, rbyte[0]};
        2'b01:   load_val = lat_unsigned ? {16'h0, rbyte[1], rbyte[0]}
                                         : {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
        default: load_val = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      read_data    <= '0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      lat_write    <= 1'b0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= address;
            lat_wdata    <= write_data;
            cnt          <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            read_data    <= load_val;
            misaligned   <= mis_c;
            out_of_range <= oor_c;
          end
        end
        RESP: begin
          read_data    <= '0;
          misaligned   <= 1'b0;
          out_of_range <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Reset gates the write so a store pending in WAIT is never committed.
  always_ff @(posedge clock) begin
    if (!reset && access && lat_write && !fault) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[{idx[k], 3'b000} +: 8] <= lat_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Testbench for data_memory_sized: one instance with LATENCY=1 and one with
// LATENCY=4 share stimulus buses; each has its own req_valid. A byte-array
// reference model predicts every response.
module tb_data_memory_sized;

  localparam int unsigned DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid1, valid4;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;

  logic        ready1, rv1, mis1, oor1;
  logic [31:0] rd1;
  logic        ready4, rv4, mis4, oor4;
  logic [31:0] rd4;

  int tests  = 0;
  int failed = 0;

  logic [7:0] ref_mem [2][DEPTH];

  always #5 clock = ~clock;

  data_memory_sized #(.DEPTH_BYTES(DEPTH), .LATENCY(1), .INIT_PATTERN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .address(address), .write_data(write_data), .resp_valid(rv1),
    .read_data(rd1), .misaligned(mis1), .out_of_range(oor1)
  );

  data_memory_sized #(.DEPTH_BYTES(DEPTH), .LATENCY(4), .INIT_PATTERN(1'b1)) dut4 (
    .clock(clock), .reset(reset), .req_valid(valid4), .req_ready(ready4),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .address(address), .write_data(write_data), .resp_valid(rv4),
    .read_data(rd4), .misaligned(mis4), .out_of_range(oor4)
  );

  function automatic logic o_ready(input int s);        return s != 0 ? ready4 : ready1; endfunction
  function automatic logic o_valid(input int s);        return s != 0 ? rv4 : rv1;       endfunction
  function automatic logic [31:0] o_rd(input int s);    return s != 0 ? rd4 : rd1;       endfunction
  function automatic logic o_mis(input int s);          return s != 0 ? mis4 : mis1;     endfunction
  function automatic logic o_oor(input int s);          return s != 0 ? oor4 : oor1;     endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: applies a store to ref_mem and returns the expected response.
  task automatic model(input int s, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic mis, output logic oor);
    int unsigned n;
    logic [63:0] last;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis  = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd3);
    last = 64'(a) + 64'(n) - 64'd1;
    oor  = (last >= 64'(DEPTH));
    rd   = '0;
    if (!mis && !oor) begin
      if (w) begin
        for (int unsigned k = 0; k < n; k++) ref_mem[s][a + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int unsigned k = 0; k < n; k++) v = v | (32'(ref_mem[s][a + k]) << (8 * k));
        if (!u && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (!u && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  // Issues one request, checks handshake timing and the response against the
  // model. Entered and left #1 after a rising edge with the DUT idle.
  task automatic req(input int s, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic mis, output logic oor);
    logic [31:0] e_rd;
    logic        e_mis, e_oor;
    int          cycles;
    int          lat;
    lat = (s != 0) ? 4 : 1;
    model(s, w, sz, u, a, wd, e_rd, e_mis, e_oor);
    chk("ready_idle", 32'(o_ready(s)), 32'd1);
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    address      = a;
    write_data   = wd;
    if (s != 0) valid4 = 1'b1; else valid1 = 1'b1;
    @(posedge clock);
    #1;
    valid1 = 1'b0;
    valid4 = 1'b0;
    cycles = 0;
    while (!o_valid(s) && cycles < 20) begin
      chk("ready_busy", 32'(o_ready(s)), 32'd0);
      @(posedge clock);
      #1;
      cycles++;
    end
    chk("latency", 32'(cycles), 32'(lat));
    chk("ready_resp", 32'(o_ready(s)), 32'd0);
    chk("read_data", o_rd(s), e_rd);
    chk("misaligned", 32'(o_mis(s)), 32'(e_mis));
    chk("out_of_range", 32'(o_oor(s)), 32'(e_oor));
    rd  = o_rd(s);
    mis = o_mis(s);
    oor = o_oor(s);
    @(posedge clock);
    #1;
    chk("pulse_end", 32'(o_valid(s)), 32'd0);
    chk("ready_back", 32'(o_ready(s)), 32'd1);
    chk("rd_cleared", o_rd(s), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis, oor;
    logic [31:0] a;
    int          r;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) ref_mem[s][i] = 8'(i);

    reset = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    address = '0; write_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(rv1), 32'd0);
    chk("rst_rd", rd1, 32'd0);
    chk("rst_mis", 32'(mis1), 32'd0);
    chk("rst_oor", 32'(oor1), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_ready", 32'(ready1), 32'd1);

    req(0, 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, rd, mis, oor);
    chk("t1_word", rd, 32'h1312_1110);

    req(0, 1'b0, 2'd0, 1'b0, 32'h080, 32'h0, rd, mis, oor);
    chk("t2_sbyte", rd, 32'hFFFF_FF80);
    req(0, 1'b0, 2'd0, 1'b1, 32'h080, 32'h0, rd, mis, oor);
    chk("t2_ubyte", rd, 32'h0000_0080);
    req(0, 1'b0, 2'd1, 1'b0, 32'h0FE, 32'h0, rd, mis, oor);
    chk("t2_shalf", rd, 32'hFFFF_FFFE);
    req(0, 1'b0, 2'd1, 1'b1, 32'h0FE, 32'h0, rd, mis, oor);
    chk("t2_uhalf", rd, 32'h0000_FFFE);

    req(0, 1'b0, 2'd2, 1'b0, 32'h022, 32'h0, rd, mis, oor);
    chk("t4_mis_load", 32'(mis), 32'd1);
    chk("t4_mis_rd", rd, 32'd0);
    req(0, 1'b1, 2'd2, 1'b0, 32'h022, 32'hFFFF_FFFF, rd, mis, oor);
    chk("t4_mis_store", 32'(mis), 32'd1);
    req(0, 1'b0, 2'd2, 1'b0, 32'h020, 32'h0, rd, mis, oor);
    chk("t4_unchanged", rd, 32'h2322_2120);
    req(0, 1'b0, 2'd3, 1'b0, 32'h020, 32'h0, rd, mis, oor);
    chk("t4_size11", 32'(mis), 32'd1);

    req(0, 1'b1, 2'd0, 1'b0, 32'h021, 32'hAABB_CCDD, rd, mis, oor);
    req(0, 1'b0, 2'd2, 1'b0, 32'h020, 32'h0, rd, mis, oor);
    chk("t3_byte_store", rd, 32'h2322_DD20);
    req(0, 1'b1, 2'd1, 1'b0, 32'h024, 32'h0000_1234, rd, mis, oor);
    req(0, 1'b0, 2'd2, 1'b0, 32'h024, 32'h0, rd, mis, oor);
    chk("t3_half_store", rd, 32'h2726_1234);

    req(0, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd, mis, oor);
    chk("t5_top_word", rd, 32'hFFFE_FDFC);
    chk("t5_top_oor", 32'(oor), 32'd0);
    req(0, 1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, rd, mis, oor);
    chk("t5_3fe_mis", 32'(mis), 32'd1);
    chk("t5_3fe_oor", 32'(oor), 32'd1);
    req(0, 1'b0, 2'd0, 1'b0, 32'h400, 32'h0, rd, mis, oor);
    chk("t5_400_oor", 32'(oor), 32'd1);
    req(0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, rd, mis, oor);
    chk("t5_nowrap_oor", 32'(oor), 32'd1);

    // LATENCY=4: reset lands two edges after acceptance, store must be dropped.
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    address = 32'h040; write_data = 32'hDEAD_BEEF;
    valid4 = 1'b1;
    @(posedge clock);
    #1;
    valid4 = 1'b0;
    chk("t6_busy", 32'(ready4), 32'd0);
    @(posedge clock);
    #1;
    chk("t6_no_resp_pre", 32'(rv4), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("t6_ready_after_rst", 32'(ready4), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_resp", 32'(rv4), 32'd0);
      @(posedge clock);
      #1;
    end
    req(1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, rd, mis, oor);
    chk("t6_dropped", rd, 32'h4342_4140);
    req(1, 1'b1, 2'd2, 1'b0, 32'h040, 32'hDEAD_BEEF, rd, mis, oor);
    req(1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, rd, mis, oor);
    chk("t6_committed", rd, 32'hDEAD_BEEF);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else if (r == 1) a = 32'd1018 + $urandom_range(0, 9);
      else if (r <= 6) a = 32'h100 + $urandom_range(0, 31);
      else             a = $urandom_range(0, DEPTH - 1);
      req(i % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), a, $urandom, rd, mis, oor);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
